disp_bcd_scan: RTL
==================

DISP_BCD_SCAN -- requirements
Module: disp_bcd_scan

Interface
REQ-001 Parameter SCAN_DIV, default 4: ce ticks per digit slot; legal range 2..256.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 R  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  refresh tick enable; one-cycle pulse from the upstream prescaler or counter chain.
REQ-005 ld  input  1  load strobe; captures dat and dp_in into the display register.
REQ-006 dat  input  16  four BCD digits, dat[3:0] = digit0 (least significant) .. dat[15:12] = digit3; fed by the cascaded decade counters' Q outputs.
REQ-007 dp_in  input  4  decimal point request per digit, bit i = digit i, active-high.
REQ-008 AN  output  4  digit anode enables, active-low, registered.
REQ-009 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 DP  output  1  decimal point segment, active-low, registered.
REQ-011 idx  output  2  index of the digit slot currently being scanned.

Function
REQ-012 Display register (16-bit digits + 4-bit dp) SHALL load dat/dp_in on any clk edge with ld=1, independent of ce; it otherwise holds.
REQ-013 Slot counter cnt (0..SCAN_DIV-1) SHALL increment on ce=1; at cnt=SCAN_DIV-1 with ce=1 it SHALL wrap to 0 and idx SHALL increment modulo 4 (3 -> 0).
REQ-014 With ce=0, cnt and idx SHALL hold.
REQ-015 AN, SEG and DP SHALL be registered from the current cnt, idx and display register, so they lag state changes by exactly one clk.
REQ-016 Dead time: while cnt=0, the next AN SHALL be 4'b1111 (all off); otherwise the next AN SHALL have only bit idx low.
REQ-017 Decode (SEG active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-018 Non-BCD codes 10..15 SHALL display a minus sign, SEG=7'h3F.
REQ-019 Next DP SHALL be the inverse of the stored dp bit for digit idx.
REQ-020 Load latency: after ld at edge k, SEG reflects the new data from edge k+1 onward when that digit is scanned; no partial digit update SHALL occur.
REQ-021 ld and ce in the same cycle SHALL both take effect; the output register uses pre-load data on that edge.

Reset
REQ-022 R=1 SHALL set display register to 0, cnt=0, idx=0, AN=4'b1111, SEG=7'h7F, DP=1 on the same edge.
REQ-023 R SHALL override ld and ce when asserted together.
REQ-024 Reset mid-scan SHALL restart at digit0 with a dead-time slot; no residual anode SHALL stay enabled.

Configuration
REQ-025 Macro DISP_LEADING_ZERO_BLANK_EN: when defined, digit i (i=3,2,1) SHALL show SEG=7'h7F if it and all higher digits equal 0; digit0 is never blanked; DP still follows dp_in.
REQ-026 When DISP_LEADING_ZERO_BLANK_EN is undefined, all digits SHALL be decoded per REQ-017/018 with no blanking.

Verification
REQ-027 R=1 one cycle, then ce=0 for 10 cycles -> AN=4'hF, SEG=7'h7F, DP=1, idx=0 throughout.
REQ-028 ld with dat=16'h1234, dp_in=4'b0100, ce=1 every cycle, SCAN_DIV=4 -> idx cycles 0,1,2,3 every 4 clocks; SEG per slot 7'h19, 7'h30, 7'h24, 7'h79; DP=0 only while idx=2; AN=4'hF for the first clock of each slot.
REQ-029 ld with dat=16'h00A7 -> digit1 SEG=7'h3F, digit0 SEG=7'h78; digits 3,2 show 7'h40 without macro and 7'h7F with DISP_LEADING_ZERO_BLANK_EN.
REQ-030 dat=16'h0000 with macro defined -> digits 3..1 blank, digit0 SEG=7'h40.
REQ-031 R asserted while idx=2, cnt=2, with ld=1 the same cycle -> next cycle idx=0, AN=4'hF, display register 0 (load ignored).
REQ-032 ce pulsed once every 5 clocks, SCAN_DIV=2 -> idx advances once per 10 clocks; outputs stable between ce pulses.

Source files
------------

// File: rtl/disp_bcd_scan.sv
// Four-digit multiplexed BCD display scanner with per-slot dead time and registered active-low outputs.
// Optional leading-zero blanking is enabled by defining DISP_LEADING_ZERO_BLANK_EN.
module disp_bcd_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        R,
  input  logic        ce,
  input  logic        ld,
  input  logic [15:0] dat,
  input  logic [3:0]  dp_in,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [1:0]  idx
);

  localparam int              CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);

  logic [15:0]   r_dig;
  logic [3:0]    r_dp;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dpo;

  logic [3:0]    w_digit;
  logic [6:0]    w_dec;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic [3:0]    w_an;
  logic          w_wrap;

  assign w_digit = r_dig[{r_idx, 2'b00} +: 4];
  assign w_wrap  = (r_cnt == CNT_MAX);

  // First clock of every slot keeps all anodes off so the segment change never ghosts.
  assign w_an    = (r_cnt == '0) ? 4'hF : ~(4'b0001 << r_idx);

  always_comb begin
    w_dec = 7'h3F;
    case (w_digit)
      4'd0: w_dec = 7'h40;
      4'd1: w_dec = 7'h79;
      4'd2: w_dec = 7'h24;
      4'd3: w_dec = 7'h30;
      4'd4: w_dec = 7'h19;
      4'd5: w_dec = 7'h12;
      4'd6: w_dec = 7'h02;
      4'd7: w_dec = 7'h78;
      4'd8: w_dec = 7'h00;
      4'd9: w_dec = 7'h10;
      default: w_dec = 7'h3F;
    endcase
  end

`ifdef DISP_LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and everything above it are zero; digit0 always shows.
  assign w_blank = ((r_idx == 2'd3) && (r_dig[15:12] == 4'd0)) ||
                   ((r_idx == 2'd2) && (r_dig[15:8]  == 8'd0)) ||
                   ((r_idx == 2'd1) && (r_dig[15:4]  == 12'd0));
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg = w_blank ? 7'h7F : w_dec;

  always_ff @(posedge clk) begin
    if (R) begin
      r_dig <= '0;
      r_dp  <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_dpo <= 1'b1;
    end else begin
      // Outputs sample pre-update state, so a same-edge load shows up one clock later.
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dpo <= ~r_dp[r_idx];
      if (ld) begin
        r_dig <= dat;
        r_dp  <= dp_in;
      end
      if (ce) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_idx <= r_idx + 2'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dpo;
  assign idx = r_idx;

endmodule
